// File: rtl/pixel_window.sv
// pixel_window: raster-to-window front end.
//   Accepts one RGB pixel per pixel_valid cycle in raster order. Keeps the two
//   previous rows in line buffers and a 3-column window register. Emits each
//   complete 3x3 neighbourhood on pixelData, with a one-cycle
//   intensity_enable pulse that follows the accepting edge by one cycle.
// Parameters: IMG_W / IMG_H set the pixels per row and the rows per frame (each >= 3).
// Ports:
//   clk, n_rst        clock; synchronous active-low reset
//   pixel_valid       pixel_in carries a pixel this cycle
//   pixel_in[23:0]    {R,G,B}
//   frame_start       restart the raster position at (0,0); a pixel in the same cycle is (0,0)
//   pixelData[215:0]  3x3 window, row-major, top-left in [215:192]
//   intensity_enable  pulse marking a new window
//   frame_done        present only when PIXWIN_FRAME_DONE_EN is defined; pulses
//                     with the window whose bottom-right pixel is (IMG_H-1, IMG_W-1)
module pixel_window #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         pixel_valid,
    input  logic [23:0]  pixel_in,
    input  logic         frame_start,
    output logic [215:0] pixelData,
    output logic         intensity_enable
`ifdef PIXWIN_FRAME_DONE_EN
    ,
    output logic         frame_done
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          last_col, last_row, win_ok;

    // Line buffers, not reset: every emitted window is rewritten by the current frame.
    logic [23:0]   lb_top_q [IMG_W];
    logic [23:0]   lb_mid_q [IMG_W];
    logic [23:0]   top_rd, mid_rd;

    // Window register: win[0] is column c-2 and win[2] is column c. Each column is {top, mid, bottom}.
    logic [2:0][71:0] win_q, win_d;
    logic [215:0]     pix_data_q, pix_data_d;
    logic             en_q, en_d;
`ifdef PIXWIN_FRAME_DONE_EN
    logic             fd_q, fd_d;
`endif

    always_comb begin
        // frame_start overrides the stored position for this cycle's pixel.
        cur_col  = frame_start ? '0 : col_q;
        cur_row  = frame_start ? '0 : row_q;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == RW'(IMG_H - 1));
        win_ok   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        top_rd   = lb_top_q[cur_col];
        mid_rd   = lb_mid_q[cur_col];

        col_d      = cur_col;
        row_d      = cur_row;
        win_d      = win_q;
        en_d       = 1'b0;
        pix_data_d = pix_data_q;
`ifdef PIXWIN_FRAME_DONE_EN
        fd_d       = 1'b0;
`endif
        if (pixel_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
            win_d = {top_rd, mid_rd, pixel_in, win_q[2], win_q[1]};
            if (win_ok) begin
                en_d = 1'b1;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        pix_data_d[215 - 24*(rr*3 + cc) -: 24] = win_d[cc][71 - 24*rr -: 24];
`ifdef PIXWIN_FRAME_DONE_EN
                fd_d = last_row && last_col;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            pix_data_q <= '0;
            en_q       <= 1'b0;
`ifdef PIXWIN_FRAME_DONE_EN
            fd_q       <= 1'b0;
`endif
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            pix_data_q <= pix_data_d;
            en_q       <= en_d;
`ifdef PIXWIN_FRAME_DONE_EN
            fd_q       <= fd_d;
`endif
        end
    end

    // Reset freezes the buffers rather than clearing them.
    always_ff @(posedge clk) begin
        if (n_rst && pixel_valid) begin
            lb_top_q[cur_col] <= mid_rd;
            lb_mid_q[cur_col] <= pixel_in;
        end
    end

    assign pixelData        = pix_data_q;
    assign intensity_enable = en_q;
`ifdef PIXWIN_FRAME_DONE_EN
    assign frame_done       = fd_q;
`endif
endmodule

// File: tb/tb_pixel_window.sv
module tb_pixel_window;
    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         pixel_valid = 1'b0;
    logic [23:0]  pixel_in = '0;
    logic         frame_start = 1'b0;
    logic [215:0] pixelData;
    logic         intensity_enable;
`ifdef PIXWIN_FRAME_DONE_EN
    logic         frame_done;
`endif

    pixel_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .n_rst(n_rst), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .frame_start(frame_start), .pixelData(pixelData), .intensity_enable(intensity_enable)
`ifdef PIXWIN_FRAME_DONE_EN
        , .frame_done(frame_done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame held as an image array plus the raster position.
    logic [23:0]  img [H][W];
    int           mr = 0, mc = 0;
    logic         exp_en = 1'b0;
    logic         exp_fd = 1'b0;
    logic [215:0] exp_data = '0;

    function automatic logic [23:0] pat(input int r, input int c);
        return {8'(r), 8'(c), 8'hA5};
    endfunction

    // Drive one cycle, then update the model with what the design should now show.
    task automatic step(input logic rst_n, input logic v, input logic fs, input logic [23:0] pix);
        n_rst = rst_n; pixel_valid = v; frame_start = fs; pixel_in = pix;
        @(posedge clk); #1;
        exp_en = 1'b0;
        exp_fd = 1'b0;
        if (!rst_n) begin
            mr = 0; mc = 0; exp_data = '0;
        end else begin
            if (fs) begin mr = 0; mc = 0; end
            if (v) begin
                img[mr][mc] = pix;
                if (mr >= 2 && mc >= 2) begin
                    exp_en = 1'b1;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            exp_data[215 - 24*(dr*3 + dc) -: 24] = img[mr-2+dr][mc-2+dc];
                    exp_fd = (mr == H-1) && (mc == W-1);
                end
                mc++;
                if (mc == W) begin mc = 0; mr++; if (mr == H) mr = 0; end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 24'h123456);
        step(1'b0, 1'b1, 1'b0, 24'h654321);
        checks++;
        if (intensity_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", intensity_enable); end
        checks++;
        if (pixelData !== 216'h0) begin errors++; $display("FAIL reset_data got %h want 0", pixelData); end
    endtask

    task automatic test_frame();
        int np = 0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b1, 1'b0, pat(mr, mc));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL frame_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL frame_data i=%0d got %h want %h", i, pixelData, exp_data); end
`ifdef PIXWIN_FRAME_DONE_EN
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL frame_done i=%0d got %0b want %0b", i, frame_done, exp_fd); end
`endif
            if (intensity_enable === 1'b1) begin
                np++;
                if (np == 1) begin
                    checks++;
                    if (pixelData[215:192] !== 24'h0000A5) begin errors++; $display("FAIL first_tl got %h want 0000a5", pixelData[215:192]); end
                    checks++;
                    if (pixelData[23:0] !== 24'h0202A5) begin errors++; $display("FAIL first_br got %h want 0202a5", pixelData[23:0]); end
                end
            end
        end
        checks++;
        if (np != 4) begin errors++; $display("FAIL frame_pulses got %0d want 4", np); end
    endtask

    task automatic test_bubbles();
        int np = 0;
        for (int i = 0; i < 2*W*H; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, 1'b0, pat(mr, mc));
            else            step(1'b1, 1'b0, 1'b0, 24'($urandom));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL bubble_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL bubble_data i=%0d got %h want %h", i, pixelData, exp_data); end
            if (intensity_enable === 1'b1) np++;
        end
        checks++;
        if (np != 4) begin errors++; $display("FAIL bubble_pulses got %0d want 4", np); end
    endtask

    task automatic test_frame_start();
        int np = 0;
        // Old-frame pixels are random so a stale value cannot pass for the pattern.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 24'($urandom));
        step(1'b1, 1'b1, 1'b1, pat(0, 0));
        for (int i = 1; i < W*H; i++) begin
            step(1'b1, 1'b1, 1'b0, pat(mr, mc));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL fs_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL fs_data i=%0d got %h want %h", i, pixelData, exp_data); end
            if (intensity_enable === 1'b1) begin
                np++;
                if (np == 1) begin
                    checks++;
                    if (i != 2*W + 2) begin errors++; $display("FAIL fs_first_pos got %0d want %0d", i, 2*W + 2); end
                    checks++;
                    if (pixelData[215:192] !== 24'h0000A5) begin errors++; $display("FAIL fs_tl got %h want 0000a5", pixelData[215:192]); end
                end
            end
        end
        checks++;
        if (np != 4) begin errors++; $display("FAIL fs_pulses got %0d want 4", np); end
    endtask

    task automatic test_two_frames();
        int np = 0;
        for (int i = 0; i < 2*W*H; i++) begin
            step(1'b1, 1'b1, 1'b0, (i < W*H) ? 24'($urandom) : pat(mr, mc));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL two_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL two_data i=%0d got %h want %h", i, pixelData, exp_data); end
`ifdef PIXWIN_FRAME_DONE_EN
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL two_fd i=%0d got %0b want %0b", i, frame_done, exp_fd); end
`endif
            if (intensity_enable === 1'b1) begin
                np++;
                if (np == 5) begin
                    checks++;
                    if (pixelData[215:192] !== 24'h0000A5) begin errors++; $display("FAIL fifth_tl got %h want 0000a5", pixelData[215:192]); end
                end
            end
        end
        checks++;
        if (np != 8) begin errors++; $display("FAIL two_pulses got %0d want 8", np); end
    endtask

    task automatic test_reset_mid();
        int np = 0;
        for (int i = 0; i < 2*W + 3; i++) step(1'b1, 1'b1, 1'b0, 24'($urandom));
        step(1'b0, 1'b1, 1'b0, 24'($urandom));
        checks++;
        if (intensity_enable !== 1'b0) begin errors++; $display("FAIL rmid_en got %0b want 0", intensity_enable); end
        checks++;
        if (pixelData !== 216'h0) begin errors++; $display("FAIL rmid_data got %h want 0", pixelData); end
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b1, 1'b0, pat(mr, mc));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL rmid_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL rmid_data i=%0d got %h want %h", i, pixelData, exp_data); end
            if (intensity_enable === 1'b1) begin
                np++;
                if (np == 1) begin
                    checks++;
                    if (i != 2*W + 2) begin errors++; $display("FAIL rmid_first_pos got %0d want %0d", i, 2*W + 2); end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(3) != 0), ($urandom_range(40) == 0), 24'($urandom));
            checks++;
            if (intensity_enable !== exp_en) begin errors++; $display("FAIL rand_en i=%0d got %0b want %0b", i, intensity_enable, exp_en); end
            checks++;
            if (pixelData !== exp_data) begin errors++; $display("FAIL rand_data i=%0d got %h want %h", i, pixelData, exp_data); end
`ifdef PIXWIN_FRAME_DONE_EN
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL rand_fd i=%0d got %0b want %0b", i, frame_done, exp_fd); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bubbles();
        test_frame_start();
        test_two_frames();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_window.md
# pixel_window

Raster-to-window front end of the cartoonifier pipeline. Accepts one 24-bit RGB pixel per valid cycle in raster order, buffers the two previous image rows in line buffers, and emits a complete 3x3 neighbourhood as a 216-bit word with a one-cycle enable pulse. It is the producer side of the intensity stage's `pixelData` / `intensity_enable` interface and feeds that stage directly.

## Interface
- `IMG_W`, 320, pixels per row (≥3)
- `IMG_H`, 240, rows per frame (≥3)
- `clk`  in  1  clock
- `n_rst`  in  1  reset, synchronous, active-low
- `pixel_valid`  in  1  `pixel_in` carries a pixel this cycle
- `pixel_in`  in  24  RGB pixel, `{R[23:16], G[15:8], B[7:0]}`
- `frame_start`  in  1  restart raster position at (0,0)
- `pixelData`  out  216  3x3 window, row-major, top-left at `[215:192]`, bottom-right at `[23:0]`
- `intensity_enable`  out  1  one-cycle pulse: `pixelData` holds a new window
- `frame_done`  out  1  only with `PIXWIN_FRAME_DONE_EN`; see Configuration

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next accepted pixel.
- Two line buffers of IMG_W x 24 bits each: `lb_top` (row r-2) and `lb_mid` (row r-1). They are not reset.
- On an accepted pixel at (r,c):
  - read `lb_top[c]` and `lb_mid[c]`
  - write `lb_top[c] <= lb_mid[c]` and `lb_mid[c] <= pixel_in`
  - shift the 3-column window register left by one column
  - load the new column `{lb_top[c], lb_mid[c], pixel_in}`
- Window is valid when r≥2 and c≥2. The window covers rows r-2..r and columns c-2..c, and its bottom-right element is `pixel_in`.
- Window packing: `[215:192]`=(r-2,c-2), `[191:168]`=(r-2,c-1), `[167:144]`=(r-2,c), `[143:120]`=(r-1,c-2), and so on down to `[23:0]`=(r,c).
- Counter advance: `col` increments; at IMG_W-1 it wraps to 0 and `row` increments. At (IMG_H-1, IMG_W-1), both counters wrap to 0, so the next frame starts automatically.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No border windows are produced.
- `frame_start`:
  - forces `row`=`col`=0.
  - If it is asserted together with `pixel_valid`, that pixel is accepted as (0,0).
  - Mid-frame it abandons the current frame. No window is produced until (2,2) of the new frame.
  - Stale line-buffer and window-register contents are never emitted, because every emitted window is fully overwritten by the current frame.
- There is no backpressure. The downstream stage accepts every pulse.

## Timing
- Reset values: `pixelData`=0, `intensity_enable`=0, `frame_done`=0, `row`=`col`=0, window register = 0.
- Latency: `intensity_enable` and the new `pixelData` are registered one cycle after the accepting edge.
- Throughput: one pixel per cycle sustained. Bubbles (`pixel_valid`=0) are allowed anywhere and produce no pulse.
- `pixelData` holds its last value while `intensity_enable` is 0.
- Reset mid-operation: outputs and counters take their reset values at the next edge. The line buffers retain their contents.
- `n_rst`=0 has priority over `frame_start`, which has priority over normal counter advance.

## Configuration
- `PIXWIN_FRAME_DONE_EN` defined:
  - adds the `frame_done` output port.
  - `frame_done` pulses for one cycle, coincident with the `intensity_enable` pulse for the window at (IMG_H-1, IMG_W-1).
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All tests use IMG_W=4, IMG_H=4 and `pixel_in`={8'(r), 8'(c), 8'hA5}.
- Reset: hold `n_rst`=0 for 2 cycles → `intensity_enable`=0, `pixelData`=216'h0.
- Back-to-back frame (16 pixels) → exactly 4 pulses, each 1 cycle after pixels (2,2), (2,3), (3,2), (3,3). On the first pulse, `[215:192]`=24'h0000A5 and `[23:0]`=24'h0202A5.
- `pixel_valid` toggling every other cycle → the same 4 windows with identical contents. Each pulse comes 1 cycle after its accepting edge. No pulse follows a bubble.
- `frame_start` with `pixel_valid` after 7 pixels → that pixel becomes (0,0). The next pulse follows new-frame pixel (2,2) and contains only new-frame values.
- Two frames with no `frame_start` → 8 pulses. The fifth pulse has `[215:192]`=24'h0000A5, with counters wrapping correctly. `n_rst`=0 asserted during row 2 → outputs are 0 at the next edge, and the next window follows a fresh (2,2).
- With `PIXWIN_FRAME_DONE_EN` → `frame_done`=1 only on the fourth pulse of each frame. Without the macro, the build succeeds without the port.
